// File: rtl/pipe_ctrl_unit.sv
// Purpose : MIPS-style pipelined controller: Decode, E/M/W control registers, next-PC select, multiply busy.
// Latency : D->E 1 cycle, D->W 2+MEM_STAGES cycles; pcsrcD/orpcsrcD/illegalD are combinational.
// Backpr. : stallE holds E and pushes a bubble into M1; flushE clears E; later stages always advance.
//
// Optional feature macro: CTRL_JAL_EN (jal decode and linkE). Undefined: opcode 000011 is illegal.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   opD, functD, equalD Decode-stage opcode, funct field and register compare result
//   stallE, flushE      hazard-unit controls for the E register
//   pcsrcD, orpcsrcD    next-PC select (00 PC+4, 01 branch, 10 jump) and its OR for F/D flush
//   illegalD            op/funct cannot be decoded; a bubble is issued instead
//   *E                  ALU / datapath controls in Execute
//   memwriteM           data memory write from the first M register
//   regwriteM/memtoregM from the last M register
//   regwriteW/memtoregW writeback controls
//   multbusy            multiply result still pending (mflo interlock)
module pipe_ctrl_unit #(
   parameter int ALUCTRL_W  = 4,
   parameter int MEM_STAGES = 1,
   parameter int MULT_LAT   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           opD,
   input  logic [5:0]           functD,
   input  logic                 equalD,
   input  logic                 stallE,
   input  logic                 flushE,
   output logic [1:0]           pcsrcD,
   output logic                 orpcsrcD,
   output logic                 illegalD,
   output logic [ALUCTRL_W-1:0] alucontrolE,
   output logic                 alusrcE,
   output logic                 regdstE,
   output logic                 zeroextE,
   output logic                 linkE,
   output logic                 regwriteE,
   output logic                 memtoregE,
   output logic                 memwriteM,
   output logic                 regwriteM,
   output logic                 memtoregM,
   output logic                 regwriteW,
   output logic                 memtoregW,
   output logic                 multbusy
);

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_JAL_EN
   localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

   // R-type funct codes
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_MFLO = 6'b010010;

   // ALU codes, zero-extended when ALUCTRL_W > 4
   localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
   localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
   localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT);

   // Control bundle carried from D into E
   typedef struct packed {
      logic                 regWrite;
      logic                 memToReg;
      logic                 memWrite;
      logic                 aluSrc;
      logic                 regDst;
      logic                 zeroExt;
`ifdef CTRL_JAL_EN
      logic                 link;
`endif
      logic [ALUCTRL_W-1:0] aluControl;
   } ctrlBundle_t;

   // Only the fields still needed downstream of E travel through M
   typedef struct packed {
      logic regWrite;
      logic memToReg;
   } memStage_t;

   ctrlBundle_t ctrlD;
   ctrlBundle_t ctrlE;
   logic        isBeq;
   logic        isBne;
   logic        isJump;
   logic        isMult;
   logic        illegal;

   logic        m1MemWrite;
   memStage_t   mReg [MEM_STAGES];
   memStage_t   wReg;
   logic [3:0]  multCnt;
   logic        loadMultE;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   always_comb begin
      ctrlD   = '0;
      isBeq   = 1'b0;
      isBne   = 1'b0;
      isJump  = 1'b0;
      isMult  = 1'b0;
      illegal = 1'b0;

      case (opD)
         OP_RTYPE: begin
            ctrlD.regDst   = 1'b1;
            ctrlD.regWrite = 1'b1;
            case (functD)
               F_ADD:  ctrlD.aluControl = ALU_ADD;
               F_SUB:  ctrlD.aluControl = ALU_SUB;
               F_AND:  ctrlD.aluControl = ALU_AND;
               F_OR:   ctrlD.aluControl = ALU_OR;
               F_SLT:  ctrlD.aluControl = ALU_SLT;
               F_MULT: begin
                  // mult writes HI/LO, not the register file
                  ctrlD.regDst   = 1'b0;
                  ctrlD.regWrite = 1'b0;
                  isMult         = 1'b1;
               end
               F_MFLO: ctrlD.regWrite = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         OP_LW: begin
            ctrlD.regWrite   = 1'b1;
            ctrlD.memToReg   = 1'b1;
            ctrlD.aluSrc     = 1'b1;
            ctrlD.aluControl = ALU_ADD;
         end
         OP_SW: begin
            ctrlD.memWrite   = 1'b1;
            ctrlD.aluSrc     = 1'b1;
            ctrlD.aluControl = ALU_ADD;
         end
         OP_BEQ: begin
            isBeq            = 1'b1;
            ctrlD.aluControl = ALU_SUB;
         end
         OP_BNE: begin
            isBne            = 1'b1;
            ctrlD.aluControl = ALU_SUB;
         end
         OP_ADDI: begin
            ctrlD.regWrite   = 1'b1;
            ctrlD.aluSrc     = 1'b1;
            ctrlD.aluControl = ALU_ADD;
         end
         OP_ANDI: begin
            ctrlD.regWrite   = 1'b1;
            ctrlD.aluSrc     = 1'b1;
            ctrlD.zeroExt    = 1'b1;
            ctrlD.aluControl = ALU_AND;
         end
         OP_ORI: begin
            ctrlD.regWrite   = 1'b1;
            ctrlD.aluSrc     = 1'b1;
            ctrlD.zeroExt    = 1'b1;
            ctrlD.aluControl = ALU_OR;
         end
         OP_SLTI: begin
            ctrlD.regWrite   = 1'b1;
            ctrlD.aluSrc     = 1'b1;
            ctrlD.aluControl = ALU_SLT;
         end
         OP_J: isJump = 1'b1;
`ifdef CTRL_JAL_EN
         OP_JAL: begin
            isJump         = 1'b1;
            ctrlD.regWrite = 1'b1;
            ctrlD.link     = 1'b1;
         end
`endif
         default: illegal = 1'b1;
      endcase

      // An undecodable instruction becomes a bubble with no PC redirect
      if (illegal) begin
         ctrlD  = '0;
         isBeq  = 1'b0;
         isBne  = 1'b0;
         isJump = 1'b0;
         isMult = 1'b0;
      end
   end

   always_comb begin
      pcsrcD = 2'b00;
      if (isJump)
         pcsrcD = 2'b10;
      else if ((isBeq && equalD) || (isBne && !equalD))
         pcsrcD = 2'b01;
   end

   assign orpcsrcD = |pcsrcD;
   assign illegalD = illegal;

   // ------------------------------------------------------------------
   // E register: flush beats stall
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset)
         ctrlE <= '0;
      else if (flushE)
         ctrlE <= '0;
      else if (!stallE)
         ctrlE <= ctrlD;
   end

   assign alucontrolE = ctrlE.aluControl;
   assign alusrcE     = ctrlE.aluSrc;
   assign regdstE     = ctrlE.regDst;
   assign zeroextE    = ctrlE.zeroExt;
   assign regwriteE   = ctrlE.regWrite;
   assign memtoregE   = ctrlE.memToReg;
`ifdef CTRL_JAL_EN
   assign linkE       = ctrlE.link;
`else
   assign linkE       = 1'b0;
`endif

   // ------------------------------------------------------------------
   // M registers. While E is held, the instruction in E must not also
   // advance, so M1 takes a bubble. A flush already empties E, so in that
   // case M1 still takes the (old) E contents.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         m1MemWrite <= 1'b0;
         for (int k = 0; k < MEM_STAGES; k++)
            mReg[k] <= '0;
      end else begin
         if (stallE && !flushE) begin
            m1MemWrite <= 1'b0;
            mReg[0]    <= '0;
         end else begin
            m1MemWrite       <= ctrlE.memWrite;
            mReg[0].regWrite <= ctrlE.regWrite;
            mReg[0].memToReg <= ctrlE.memToReg;
         end
         for (int k = 1; k < MEM_STAGES; k++)
            mReg[k] <= mReg[k-1];
      end
   end

   assign memwriteM = m1MemWrite;
   assign regwriteM = mReg[MEM_STAGES-1].regWrite;
   assign memtoregM = mReg[MEM_STAGES-1].memToReg;

   // ------------------------------------------------------------------
   // W register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset)
         wReg <= '0;
      else
         wReg <= mReg[MEM_STAGES-1];
   end

   assign regwriteW = wReg.regWrite;
   assign memtoregW = wReg.memToReg;

   // ------------------------------------------------------------------
   // Multiply busy counter: loaded only when a mult really enters E, so a
   // stalled or flushed mult never starts the interlock window.
   // ------------------------------------------------------------------
   assign loadMultE = isMult && !stallE && !flushE;

   always_ff @(posedge clk) begin
      if (!reset)
         multCnt <= 4'd0;
      else if (loadMultE)
         multCnt <= MULT_LOAD;
      else if (multCnt != 4'd0)
         multCnt <= multCnt - 4'd1;
   end

   assign multbusy = (multCnt != 4'd0);

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised successor of the 5-stage MIPS pipelined controller.
- Decodes opD/functD in Decode and produces the next-PC select.
- Carries the control bundle through E, M (configurable depth) and W registers, with per-stage stall/flush.
- Adds bne and immediate ops, plus a multiply-latency busy counter the hazard unit uses for mflo interlock.

Parameters:
- ALUCTRL_W, 4, width of alucontrol bundle (min 4).
- MEM_STAGES, 1, number of memory-stage registers (1..3); slow data memory uses >1.
- MULT_LAT, 4, cycles multiply result is unavailable after mult enters E (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- opD  in  6  opcode, Decode stage.
- functD  in  6  funct field, Decode stage.
- equalD  in  1  register compare result from Decode.
- stallE  in  1  hold E register (from hazard unit).
- flushE  in  1  load bubble into E register.
- pcsrcD  out  2  00 PC+4, 01 branch target, 10 jump target.
- orpcsrcD  out  1  |pcsrcD, flushes the fetch/decode register.
- illegalD  out  1  undecodable op/funct in Decode.
- alucontrolE  out  ALUCTRL_W  ALU operation.
- alusrcE, regdstE, zeroextE  out  1 each  datapath selects (zeroextE for andi/ori).
- linkE  out  1  writes PC+8 to $31 (jal).
- regwriteE, memtoregE  out  1 each  for hazard/forwarding.
- memwriteM  out  1  data memory write, first M register.
- regwriteM, memtoregM  out  1 each  from last M register.
- regwriteW, memtoregW  out  1 each  writeback.
- multbusy  out  1  multiply result pending.

Behaviour:
- Decode is combinational.
  - R=000000: funct add 100000, sub 100010, and 100100, or 100101, slt 101010, mult 011000, mflo 010010.
  - I-type opcodes: lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, slti 001010.
  - Jump opcodes: j 000010, jal 000011.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111; unused upper bits 0.
  - lw/sw/addi use ADD, beq/bne use SUB, andi AND, ori OR, slti SLT.
- regwrite is asserted for R-type except mult, and for lw, addi, andi, ori, slti, jal.
- illegalD is asserted for any other op/funct; the bundle is forced all-zero, so a bubble is issued.
- pcsrcD:
  - 10 if j/jal.
  - Else 01 if (beq & equalD) | (bne & ~equalD).
  - Else 00.
  - Combinational, no register.
- E register update, in priority order:
  - reset low: E cleared.
  - Else flushE: E cleared.
  - Else stallE: E holds.
  - Else E loads the D bundle.
- M register 1 update:
  - reset low: cleared.
  - stallE=1 and flushE=0: M1 loads a bubble (zeros).
  - Otherwise: loads E.
- M registers k>1 and the W register always shift, cleared on reset.
- Latency D->E is 1 cycle; D->W is 2+MEM_STAGES cycles.
- All outputs reset to 0, with pcsrcD/orpcsrcD/illegalD following combinational inputs.
- Multiply counter cnt is 4-bit, reset 0.
  - On any edge where E loads a mult (not stalled, not flushed), cnt <= MULT_LAT; a mult arriving while busy reloads cnt.
  - Otherwise cnt decrements when nonzero.
  - multbusy = (cnt != 0); it rises the cycle mult is in E and stays high exactly MULT_LAT cycles.
  - A flushed mult never loads cnt.
  - Reset mid-count clears cnt immediately.

Optional Feature:
- Macro CTRL_JAL_EN.
- Defined: jal decodes to pcsrcD=10, regwrite=1, linkE=1 in E.
- Undefined: opcode 000011 is illegal, giving illegalD=1, a bubble and pcsrcD=00; linkE is tied 0.

Test Plan:
- Reset held low 2 cycles with opD=100011 → all registered outputs 0. Release → regwriteE=1, memtoregE=1, alusrcE=1, alucontrolE=0010 next cycle; W stage set after 2+MEM_STAGES cycles.
- bne with equalD=0 → pcsrcD=01, orpcsrcD=1. With equalD=1 → 00. beq mirrors this. j → 10 regardless of equalD.
- sw decoded, stallE pulsed 1 cycle → E holds sw. M1 sees a bubble that cycle, then memwriteM=1 one cycle later. Same with flushE=1 → sw never reaches M.
- mult with MULT_LAT=4 → multbusy high exactly 4 cycles starting the cycle mult is in E. Flushed mult → multbusy stays 0. Reset at count 2 → 0.
- opD=000000, functD=000001 → illegalD=1, E bundle all zero. Macro off and opD=000011 → illegalD=1. Macro on → linkE=1, regwriteW=1 later.
- MEM_STAGES=3: lw reaches regwriteW exactly 5 cycles after D; memwriteM for sw at 2 cycles.
